// File: rtl/msg_checker.sv
// Scans MSG_LEN bytes of a decrypted message in a registered-read memory and
// reports whether every byte is a space or a lowercase letter.
module msg_checker #(
  parameter int MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_flag,
  output logic [7:0] addr_dec,
  input  logic [7:0] rddata_dec,
  output logic       busy,
  output logic       done_flag,
  output logic       pass,
  output logic [7:0] fail_idx
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    CHECK,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(MSG_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic       pass_q, pass_d;
  logic [7:0] fail_q, fail_d;
  logic       byte_ok;
  logic       is_last;

  assign byte_ok = (rddata_dec == 8'h20) ||
                   ((rddata_dec >= 8'h61) &&
                    (rddata_dec <= 8'h7A));
  assign is_last = (i_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      pass_q  <= 1'b0;
      fail_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_flag) state_d = FETCH;
      FETCH: state_d = WAIT;
      WAIT:  state_d = CHECK;
      CHECK: begin
        if (!byte_ok || is_last) state_d = DONE;
        else                     state_d = FETCH;
      end
      DONE:  if (start_flag) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Index and result registers; the result is only rewritten in CHECK.
  always_comb begin
    i_d    = i_q;
    pass_d = pass_q;
    fail_d = fail_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_flag) i_d = 8'd0;
      end
      CHECK: begin
        if (!byte_ok) begin
          pass_d = 1'b0;
          fail_d = i_q;
        end else if (is_last) begin
          pass_d = 1'b1;
          fail_d = 8'd0;
        end else begin
          i_d = i_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q == FETCH) ||
                (state_q == WAIT)  ||
                (state_q == CHECK);
    done_flag = (state_q == DONE);
    addr_dec  = i_q;
    pass      = pass_q;
    fail_idx  = fail_q;
  end

endmodule

// File: tb/tb_msg_checker.sv
// Directed bench for msg_checker: 32-byte and 1-byte instances, each
// reading from a one-cycle registered-read memory model.
module tb_msg_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] addr;
  logic [7:0] rdata;
  logic       busy, done, pass;
  logic [7:0] fidx;

  logic       start1;
  logic [7:0] addr1;
  logic [7:0] rdata1;
  logic       busy1, done1, pass1;
  logic [7:0] fidx1;

  logic [7:0] mem [256];
  logic [7:0] b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rdata <= mem[addr];
  always @(posedge clk) rdata1 <= b1;

  msg_checker #(.MSG_LEN(32)) u_dut (
    .clk(clk), .reset(reset), .start_flag(start),
    .addr_dec(addr), .rddata_dec(rdata),
    .busy(busy), .done_flag(done),
    .pass(pass), .fail_idx(fidx)
  );

  msg_checker #(.MSG_LEN(1)) u_dut1 (
    .clk(clk), .reset(reset), .start_flag(start1),
    .addr_dec(addr1), .rddata_dec(rdata1),
    .busy(busy1), .done_flag(done1),
    .pass(pass1), .fail_idx(fidx1)
  );

  task automatic fill(input logic [7:0] v);
    for (int k = 0; k < 256; k++) mem[k] = v;
  endtask

  // Pulse start for one edge and follow the pass until done_flag rises.
  // edges counts the start edge as edge 1; -1 means timeout.
  task automatic run_pass(output int edges, output int max_addr,
                          output int walk_err, output int overlap);
    bit got;
    got = 0;
    edges = -1; max_addr = 0; walk_err = 0; overlap = 0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 2000 && !got; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (busy && done) overlap++;
      if (int'(addr) > max_addr) max_addr = int'(addr);
      if (busy && addr !== 8'((n - 1) / 3)) walk_err++;
      if (done === 1'b1) begin
        got = 1;
        edges = n;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; start = 1'b1; start1 = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %0b want 0", pass); end
    if (fidx !== 8'd0) begin errors++; $display("FAIL reset_fidx got %0d want 0", fidx); end
    if (addr !== 8'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", addr); end
    @(negedge clk);
    reset = 1'b0; start = 1'b0; start1 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_stay got busy %0b want 0", busy); end
  endtask

  task automatic test_all_legal;
    int e, ma, we, ov;
    fill(8'h61);
    run_pass(e, ma, we, ov);
    checks += 6;
    if (e !== 97) begin errors++; $display("FAIL legal_edges got %0d want 97", e); end
    if (pass !== 1'b1) begin errors++; $display("FAIL legal_pass got %0b want 1", pass); end
    if (fidx !== 8'd0) begin errors++; $display("FAIL legal_fidx got %0d want 0", fidx); end
    if (we !== 0) begin errors++; $display("FAIL legal_walk got %0d bad want 0", we); end
    if (ma !== 31) begin errors++; $display("FAIL legal_maxaddr got %0d want 31", ma); end
    if (ov !== 0) begin errors++; $display("FAIL legal_overlap got %0d want 0", ov); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL legal_hold got done %0b busy %0b want 1 0", done, busy);
    end
  endtask

  task automatic test_early_fail;
    int e, ma, we, ov;
    fill(8'h7A);
    mem[5] = 8'h41;
    run_pass(e, ma, we, ov);
    checks += 5;
    if (e !== 19) begin errors++; $display("FAIL early_edges got %0d want 19", e); end
    if (pass !== 1'b0) begin errors++; $display("FAIL early_pass got %0b want 0", pass); end
    if (fidx !== 8'd5) begin errors++; $display("FAIL early_fidx got %0d want 5", fidx); end
    if (ma !== 5) begin errors++; $display("FAIL early_maxaddr got %0d want 5", ma); end
    if (we !== 0) begin errors++; $display("FAIL early_walk got %0d bad want 0", we); end
  endtask

  task automatic test_boundary;
    int e, ma, we, ov;
    fill(8'h61);
    mem[31] = 8'h7B;
    run_pass(e, ma, we, ov);
    checks += 3;
    if (e !== 97) begin errors++; $display("FAIL b7b_edges got %0d want 97", e); end
    if (pass !== 1'b0) begin errors++; $display("FAIL b7b_pass got %0b want 0", pass); end
    if (fidx !== 8'd31) begin errors++; $display("FAIL b7b_fidx got %0d want 31", fidx); end

    fill(8'h61);
    mem[0] = 8'h60;
    run_pass(e, ma, we, ov);
    checks += 3;
    if (e !== 4) begin errors++; $display("FAIL b60_edges got %0d want 4", e); end
    if (pass !== 1'b0) begin errors++; $display("FAIL b60_pass got %0b want 0", pass); end
    if (fidx !== 8'd0) begin errors++; $display("FAIL b60_fidx got %0d want 0", fidx); end

    fill(8'h61);
    mem[3] = 8'h1F;
    run_pass(e, ma, we, ov);
    checks += 2;
    if (e !== 13) begin errors++; $display("FAIL b1f_edges got %0d want 13", e); end
    if (fidx !== 8'd3) begin errors++; $display("FAIL b1f_fidx got %0d want 3", fidx); end

    fill(8'h61);
    mem[0] = 8'h1F;
    run_pass(e, ma, we, ov);
    checks += 2;
    if (pass !== 1'b0) begin errors++; $display("FAIL b1f0_pass got %0b want 0", pass); end
    if (fidx !== 8'd0) begin errors++; $display("FAIL b1f0_fidx got %0d want 0", fidx); end

    for (int k = 0; k < 32; k++) mem[k] = k[0] ? 8'h7A : 8'h20;
    run_pass(e, ma, we, ov);
    checks += 2;
    if (e !== 97) begin errors++; $display("FAIL sp7a_edges got %0d want 97", e); end
    if (pass !== 1'b1) begin errors++; $display("FAIL sp7a_pass got %0b want 1", pass); end
  endtask

  task automatic test_reset_mid;
    int e, ma, we, ov;
    bit hit;
    hit = 0;
    fill(8'h7A);
    mem[5] = 8'h41;
    run_pass(e, ma, we, ov);
    fill(8'h61);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(posedge clk); #1;
      if (addr === 8'd10) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL mid_reach got addr %0d want 10", addr); end
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %0b want 0", done); end
    if (pass !== 1'b0) begin errors++; $display("FAIL mid_pass got %0b want 0", pass); end
    if (fidx !== 8'd0) begin errors++; $display("FAIL mid_fidx got %0d want 0", fidx); end
    if (addr !== 8'd0) begin errors++; $display("FAIL mid_addr got %0d want 0", addr); end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    run_pass(e, ma, we, ov);
    checks += 3;
    if (e !== 97) begin errors++; $display("FAIL mid_edges got %0d want 97", e); end
    if (pass !== 1'b1) begin errors++; $display("FAIL mid_rpass got %0b want 1", pass); end
    if (we !== 0) begin errors++; $display("FAIL mid_walk got %0d bad want 0", we); end
  endtask

  task automatic test_hold_start;
    int cnt, ov, first, second, consec;
    bit prev;
    cnt = 0; ov = 0; first = -1; second = -1; consec = 0; prev = 0;
    fill(8'h61);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (busy && done) ov++;
      if (done) begin
        cnt++;
        if (prev) consec++;
        if (first < 0) first = n;
        else if (second < 0) second = n;
      end
      prev = done;
    end
    checks += 5;
    if (first !== 97) begin errors++; $display("FAIL hold_first got %0d want 97", first); end
    if (second !== 194) begin errors++; $display("FAIL hold_second got %0d want 194", second); end
    if (cnt !== 2) begin errors++; $display("FAIL hold_count got %0d want 2", cnt); end
    if (consec !== 0) begin errors++; $display("FAIL hold_consec got %0d want 0", consec); end
    if (ov !== 0) begin errors++; $display("FAIL hold_overlap got %0d want 0", ov); end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_len1;
    int e;
    e = -1;
    b1 = 8'h20;
    @(negedge clk);
    start1 = 1'b1;
    for (int n = 1; n <= 50 && e < 0; n++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      if (done1) e = n;
    end
    checks += 4;
    if (e !== 4) begin errors++; $display("FAIL len1_edges got %0d want 4", e); end
    if (pass1 !== 1'b1) begin errors++; $display("FAIL len1_pass got %0b want 1", pass1); end
    if (fidx1 !== 8'd0) begin errors++; $display("FAIL len1_fidx got %0d want 0", fidx1); end
    if (addr1 !== 8'd0) begin errors++; $display("FAIL len1_addr got %0d want 0", addr1); end
    e = -1;
    b1 = 8'h7B;
    @(negedge clk);
    start1 = 1'b1;
    for (int n = 1; n <= 50 && e < 0; n++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      if (done1) e = n;
    end
    checks += 2;
    if (e !== 4) begin errors++; $display("FAIL len1f_edges got %0d want 4", e); end
    if (pass1 !== 1'b0) begin errors++; $display("FAIL len1f_pass got %0b want 0", pass1); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start1 = 1'b0;
    b1 = 8'h20;
    fill(8'h00);
    test_reset;
    test_all_legal;
    test_early_fail;
    test_boundary;
    test_reset_mid;
    test_hold_start;
    test_len1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
